// File: rtl/ibex_compressed_encoder.sv
// ibex_compressed_encoder: maps RV32I instructions to RVC parcels and packs them into 32-bit words.
// Define COMPRESSED_ENCODER_CLW_EN to also emit C.LW / C.SW for x8..x15 operands.
module ibex_compressed_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      word_o,
    output logic             residue_valid_o,
    output logic [CNT_W-1:0] ncomp_o
);
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm_i, imm_s;

    assign opc   = instr_i[6:0];
    assign rd    = instr_i[11:7];
    assign f3    = instr_i[14:12];
    assign rs1   = instr_i[19:15];
    assign rs2   = instr_i[24:20];
    assign f7    = instr_i[31:25];
    assign imm_i = instr_i[31:20];
    assign imm_s = {instr_i[31:25], instr_i[11:7]};

    logic imm6, addi_base, add_base, jr_base;
    logic c_ebreak, c_li, c_addi, c_slli, c_mv, c_add, c_jr, c_jalr, c_lwsp, c_swsp, c_lw, c_sw;

    // imm fits a 6-bit signed field when bits [11:5] are all sign copies
    assign imm6      = (&imm_i[11:5]) | ~(|imm_i[11:5]);
    assign addi_base = opc == OPC_OP_IMM && f3 == 3'b000 && imm6 && rd != 5'd0;
    assign add_base  = opc == OPC_OP && f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0;
    assign jr_base   = opc == OPC_JALR && f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0;

    assign c_ebreak = instr_i == 32'h0010_0073;
    assign c_li     = addi_base && rs1 == 5'd0;
    assign c_addi   = addi_base && rs1 == rd;
    assign c_slli   = opc == OPC_OP_IMM && f3 == 3'b001 && f7 == 7'd0 && rs1 == rd && rd != 5'd0;
    assign c_mv     = add_base && rs1 == 5'd0;
    assign c_add    = add_base && rs1 == rd;
    assign c_jr     = jr_base && rd == 5'd0;
    assign c_jalr   = jr_base && rd == 5'd1;
    assign c_lwsp   = opc == OPC_LOAD && f3 == 3'b010 && rs1 == 5'd2 && rd != 5'd0 &&
                      imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'd0;
    assign c_swsp   = opc == OPC_STORE && f3 == 3'b010 && rs1 == 5'd2 &&
                      imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'd0;
`ifdef COMPRESSED_ENCODER_CLW_EN
    assign c_lw = opc == OPC_LOAD && f3 == 3'b010 && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                  imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0;
    assign c_sw = opc == OPC_STORE && f3 == 3'b010 && rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                  imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0;
`else
    assign c_lw = 1'b0;
    assign c_sw = 1'b0;
`endif

    logic        pass, match, is16;
    logic [15:0] cparcel, parcel;

    // low bits != 2'b11 means the source already handed us an RVC parcel
    assign pass  = instr_i[1:0] != 2'b11;
    assign match = !pass && (c_ebreak || c_li || c_addi || c_slli || c_mv || c_add ||
                             c_jr || c_jalr || c_lwsp || c_swsp || c_lw || c_sw);
    assign is16  = pass || match;

    assign cparcel = c_ebreak ? 16'h9002 :
                     c_li     ? {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01} :
                     c_addi   ? {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01} :
                     c_slli   ? {4'b0000, rd, rs2, 2'b10} :
                     c_mv     ? {4'b1000, rd, rs2, 2'b10} :
                     c_add    ? {4'b1001, rd, rs2, 2'b10} :
                     c_jr     ? {4'b1000, rs1, 5'd0, 2'b10} :
                     c_jalr   ? {4'b1001, rs1, 5'd0, 2'b10} :
                     c_lwsp   ? {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10} :
                     c_swsp   ? {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10} :
                     c_lw     ? {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00} :
                                {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
    assign parcel  = pass ? instr_i[15:0] : cparcel;

    logic             out_valid_q, out_valid_d, res_valid_q, res_valid_d;
    logic [31:0]      word_q, word_d;
    logic [15:0]      res_q, res_d;
    logic [CNT_W-1:0] ncomp_q, ncomp_d;
    logic             space, xfer;

    assign space      = !out_valid_q || out_ready_i;
    assign in_ready_o = !flush_i && space;
    assign xfer       = in_valid_i && in_ready_o;

    always_comb begin
        out_valid_d = out_valid_q && !out_ready_i;
        word_d      = word_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        ncomp_d     = ncomp_q + CNT_W'(xfer && match);
        if (xfer) begin
            if (is16 && !res_valid_q) begin
                res_d       = parcel;
                res_valid_d = 1'b1;
            end else if (is16) begin
                word_d      = {parcel, res_q};
                out_valid_d = 1'b1;
                res_valid_d = 1'b0;
            end else if (!res_valid_q) begin
                word_d      = instr_i;
                out_valid_d = 1'b1;
            end else begin
                word_d      = {instr_i[15:0], res_q};
                res_d       = instr_i[31:16];
                out_valid_d = 1'b1;
            end
        end else if (flush_i && space && res_valid_q) begin
            word_d      = {16'h0001, res_q};
            out_valid_d = 1'b1;
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            word_q      <= 32'd0;
            res_valid_q <= 1'b0;
            res_q       <= 16'd0;
            ncomp_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            word_q      <= word_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            ncomp_q     <= ncomp_d;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign word_o          = word_q;
    assign residue_valid_o = res_valid_q;
    assign ncomp_o         = ncomp_q;
endmodule

// File: tb/tb_ibex_compressed_encoder.sv
// tb_ibex_compressed_encoder: randomized stream checked against a parcel-queue model plus an RVC expander.
module tb_ibex_compressed_encoder;
    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] instr;
    logic        in_ready_o, out_valid_o, residue_valid_o;
    logic [31:0] word_o;
    logic [15:0] ncomp_o;

    ibex_compressed_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o), .instr_i(instr),
        .flush_i(flush), .out_valid_o(out_valid_o), .out_ready_i(out_ready), .word_o(word_o),
        .residue_valid_o(residue_valid_o), .ncomp_o(ncomp_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference compressor from field values and integer offsets; returns {matched, parcel}
    function automatic logic [16:0] mc(input logic [31:0] x);
        int op, rd, f3, rs1, rs2, f7, ii, si, v;
        op = int'(x[6:0]); rd = int'(x[11:7]); f3 = int'(x[14:12]);
        rs1 = int'(x[19:15]); rs2 = int'(x[24:20]); f7 = int'(x[31:25]);
        ii = int'($signed(x[31:20]));
        si = int'($signed({x[31:25], x[11:7]}));
        v = -1;
        if (x == 32'h0010_0073) v = 'h9002;
        else if (op == 'h13 && f3 == 0 && rd != 0 && ii >= -32 && ii < 32 && (rs1 == 0 || rs1 == rd))
            v = (rs1 == 0 ? 'h4001 : 'h0001) | (((ii >> 5) & 1) << 12) | (rd << 7) | ((ii & 31) << 2);
        else if (op == 'h13 && f3 == 1 && f7 == 0 && rd != 0 && rs1 == rd)
            v = (rd << 7) | (rs2 << 2) | 2;
        else if (op == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && (rs1 == 0 || rs1 == rd))
            v = (rs1 == 0 ? 'h8002 : 'h9002) | (rd << 7) | (rs2 << 2);
        else if (op == 'h67 && f3 == 0 && ii == 0 && rs1 != 0 && rd <= 1)
            v = 'h8002 | (rd << 12) | (rs1 << 7);
        else if (op == 'h03 && f3 == 2 && rs1 == 2 && rd != 0 && ii >= 0 && ii < 256 && ii % 4 == 0)
            v = 'h4002 | (((ii >> 5) & 1) << 12) | (rd << 7) | (((ii >> 2) & 7) << 4) | (((ii >> 6) & 3) << 2);
        else if (op == 'h23 && f3 == 2 && rs1 == 2 && si >= 0 && si < 256 && si % 4 == 0)
            v = 'hC002 | (((si >> 2) & 15) << 9) | (((si >> 6) & 3) << 7) | (rs2 << 2);
`ifdef COMPRESSED_ENCODER_CLW_EN
        else if (op == 'h03 && f3 == 2 && rd >= 8 && rd < 16 && rs1 >= 8 && rs1 < 16 && ii >= 0 && ii < 128 && ii % 4 == 0)
            v = 'h4000 | (((ii >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((ii >> 2) & 1) << 6) | (((ii >> 6) & 1) << 5) | ((rd - 8) << 2);
        else if (op == 'h23 && f3 == 2 && rs2 >= 8 && rs2 < 16 && rs1 >= 8 && rs1 < 16 && si >= 0 && si < 128 && si % 4 == 0)
            v = 'hC000 | (((si >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((si >> 2) & 1) << 6) | (((si >> 6) & 1) << 5) | ((rs2 - 8) << 2);
`endif
        return v < 0 ? 17'd0 : {1'b1, v[15:0]};
    endfunction

    // RVC expander for the subset the encoder can produce
    function automatic logic [31:0] exp16(input logic [15:0] p);
        logic [11:0] imm;
        logic [7:0]  o8;
        logic [6:0]  o7;
        imm = {{6{p[12]}}, p[12], p[6:2]};
        if (p[1:0] == 2'b01 && p[15:13] == 3'b010) return {imm, 5'd0, 3'b000, p[11:7], 7'h13};
        if (p[1:0] == 2'b01 && p[15:13] == 3'b000) return {imm, p[11:7], 3'b000, p[11:7], 7'h13};
        if (p[1:0] == 2'b10 && p[15:13] == 3'b000) return {7'd0, p[6:2], p[11:7], 3'b001, p[11:7], 7'h13};
        if (p[1:0] == 2'b10 && p[15:13] == 3'b100) begin
            if (!p[12]) return p[6:2] == 5'd0 ? {12'd0, p[11:7], 3'b000, 5'd0, 7'h67}
                                              : {7'd0, p[6:2], 5'd0, 3'b000, p[11:7], 7'h33};
            if (p[6:2] != 5'd0) return {7'd0, p[6:2], p[11:7], 3'b000, p[11:7], 7'h33};
            return p[11:7] == 5'd0 ? 32'h0010_0073 : {12'd0, p[11:7], 3'b000, 5'd1, 7'h67};
        end
        if (p[1:0] == 2'b10 && p[15:13] == 3'b010) begin
            o8 = {p[3:2], p[12], p[6:4], 2'b00};
            return {4'd0, o8, 5'd2, 3'b010, p[11:7], 7'h03};
        end
        if (p[1:0] == 2'b10 && p[15:13] == 3'b110) begin
            o8 = {p[8:7], p[12:9], 2'b00};
            return {4'd0, o8[7:5], p[6:2], 5'd2, 3'b010, o8[4:0], 7'h23};
        end
        o7 = {p[5], p[12:10], p[6], 2'b00};
        if (p[1:0] == 2'b00 && p[15:13] == 3'b010) return {5'd0, o7, 2'b01, p[9:7], 3'b010, 2'b01, p[4:2], 7'h03};
        if (p[1:0] == 2'b00 && p[15:13] == 3'b110) return {5'd0, o7[6:5], 2'b01, p[4:2], 2'b01, p[9:7], 3'b010, o7[4:0], 7'h23};
        return 32'd0;
    endfunction

    // model: halfword stream awaiting pairing, words awaiting the sink
    logic [15:0] hq[$];
    logic [31:0] wq[$];
    logic [15:0] ncomp_m;
    logic [16:0] r;
    bit          accepted, space_m;

    always @(posedge clk) begin
        accepted = 1'b0;
        if (rst) begin
            hq.delete(); wq.delete(); ncomp_m = 16'd0;
        end else begin
            space_m = wq.size() == 0 || out_ready;
            if (space_m && wq.size() > 0) void'(wq.pop_front());
            accepted = in_valid && !flush && space_m;
            if (accepted) begin
                r = mc(instr);
                if (instr[1:0] != 2'b11) hq.push_back(instr[15:0]);
                else if (r[16]) begin
                    hq.push_back(r[15:0]);
                    ncomp_m++;
                    chk("model_expand", exp16(r[15:0]), instr);
                end else begin
                    hq.push_back(instr[15:0]);
                    hq.push_back(instr[31:16]);
                end
            end else if (flush && space_m && hq.size() == 1) hq.push_back(16'h0001);
            while (hq.size() >= 2) begin
                wq.push_back({hq[1], hq[0]});
                void'(hq.pop_front());
                void'(hq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready_o, !flush && (wq.size() == 0 || out_ready));
            chk("out_valid", out_valid_o, wq.size() != 0);
            if (wq.size() != 0) chk("word", word_o, wq[0]);
            chk("residue_valid", residue_valid_o, hq.size() == 1);
            chk("ncomp", ncomp_o, ncomp_m);
        end
    end

    task automatic send(input logic [31:0] x);
        in_valid = 1'b1;
        instr = x;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (accepted) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        miscompares++;
        $display("FAIL send_timeout: instr %h never accepted", x);
    endtask

    function automatic logic [4:0] pick_reg();
        int k;
        k = $urandom_range(0, 3);
        return k == 0 ? 5'($urandom_range(0, 2)) : k == 1 ? 5'($urandom_range(8, 15)) : 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2, rs1s;
        logic [11:0] is, ow, op;
        int v;
        rd = pick_reg(); rs2 = pick_reg();
        v = $urandom_range(0, 2);
        rs1 = v == 0 ? 5'd0 : v == 1 ? rd : pick_reg();
        rs1s = $urandom_range(0, 1) ? 5'd2 : pick_reg();
        v = int'($urandom_range(0, 80)) - 40;
        is = $urandom_range(0, 3) == 0 ? 12'($urandom) : v[11:0];
        v = 4 * int'($urandom_range(0, 70));
        ow = $urandom_range(0, 3) == 0 ? 12'($urandom) : v[11:0];
        v = 4 * int'($urandom_range(0, 35));
        op = v[11:0];
        case ($urandom_range(0, 11))
            0:  return 32'h0010_0073;
            1:  return {is, rs1, 3'b000, rd, 7'h13};
            2:  return {($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, 5'($urandom), rs1, 3'b001, rd, 7'h13};
            3:  return {($urandom_range(0, 5) == 0) ? 7'h20 : 7'h00, rs2, rs1, ($urandom_range(0, 5) == 0) ? 3'b111 : 3'b000, rd, 7'h33};
            4:  return {($urandom_range(0, 3) == 0) ? is : 12'd0, pick_reg(), 3'b000, ($urandom_range(0, 2) == 2) ? rd : 5'($urandom_range(0, 1)), 7'h67};
            5:  return {ow, rs1s, 3'b010, rd, 7'h03};
            6:  return {ow[11:5], rs2, rs1s, 3'b010, ow[4:0], 7'h23};
            7:  return {16'($urandom), 14'($urandom), 2'($urandom_range(0, 2))};
            8:  return $urandom | 32'h3;
            9:  return {op, 5'($urandom_range(8, 15)), 3'b010, 5'($urandom_range(8, 15)), 7'h03};
            10: return {op[11:5], 5'($urandom_range(8, 15)), 5'($urandom_range(8, 15)), 3'b010, op[4:0], 7'h23};
            default: return {20'($urandom), rd, 7'h37};
        endcase
    endfunction

    initial begin
        logic [31:0] cur;
        int n, guard;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = 32'd0;
        chk("lit_li", mc(32'hFFF0_0293), {1'b1, 16'h52FD});
        chk("lit_addi", mc(32'h0012_8293), {1'b1, 16'h0285});
        chk("lit_lwsp", mc(32'h0081_2483), {1'b1, 16'h44A2});
        chk("lit_jr", mc(32'h0000_8067), {1'b1, 16'h8082});
        chk("lit_ebreak", mc(32'h0010_0073), {1'b1, 16'h9002});
        chk("lit_addi_oor", mc(32'h0400_8093), 17'd0);
        chk("lit_add", mc(32'h0031_00B3), 17'd0);
`ifdef COMPRESSED_ENCODER_CLW_EN
        chk("lit_sw", mc(32'h0094_2223), {1'b1, 16'hC044});
`else
        chk("lit_sw", mc(32'h0094_2223), 17'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_word", word_o, 32'd0);
        chk("rst_residue", residue_valid_o, 1'b0);
        chk("rst_ncomp", ncomp_o, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(32'hFFF0_0293);
        send(32'h0012_8293);
        @(negedge clk);
        chk("dir_addi_word", word_o, 32'h0285_52FD);
        chk("dir_addi_ncomp", ncomp_o, 16'd2);
        @(posedge clk); #1;
        send(32'h0010_0073);
        send(32'h0031_00B3);
        @(negedge clk);
        chk("dir_ebreak_word", word_o, 32'h00B3_9002);
        chk("dir_ebreak_res", residue_valid_o, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("dir_flush_word", word_o, 32'h0001_0031);
        @(posedge clk); #1;
        send(32'h0081_2483);
        send(32'h0000_8067);
        @(negedge clk);
        chk("dir_lw_jr_word", word_o, 32'h8082_44A2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h0400_8093);
        in_valid = 1'b1;
        instr = 32'h0012_8293;
        repeat (4) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready_o, 1'b0);
            chk("hold_word", word_o, 32'h0400_8093);
            chk("hold_ncomp", ncomp_o, 16'd5);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h0012_8293);

        n = 0; guard = 0;
        cur = rand_instr();
        while (n < 10000 && guard < 60000) begin
            rst = guard == 8000;
            in_valid = $urandom_range(0, 3) != 0;
            instr = cur;
            flush = $urandom_range(0, 24) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
            guard++;
            if (accepted) begin
                n++;
                cur = rand_instr();
            end
        end
        rst = 1'b0;
        if (n < 10000) begin
            miscompares++;
            $display("FAIL random_stream: only %0d of 10000 instructions accepted", n);
        end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 20 && (wq.size() != 0 || hq.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", wq.size() + hq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
